// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel switch debouncer: per-channel
// state encoding and default settle-counter width.
package debounce_pkg;

  localparam int unsigned DEFAULT_CH = 4;
  localparam int unsigned DEFAULT_N  = 22;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT0 = 2'b01,
    ONE   = 2'b10,
    WAIT1 = 2'b11
  } db_state_e;

endpackage

// File: rtl/debounce_multi_if.sv
// Switch-in / debounced-out bundle between the board front end and the
// debouncer; master drives raw switches, slave returns levels and ticks.
interface debounce_multi_if #(
  parameter int unsigned CH = 4
);
  logic [CH-1:0] sw;
  logic [CH-1:0] db_level;
  logic [CH-1:0] rise_tick;
  logic [CH-1:0] fall_tick;

  modport master (output sw, input db_level, rise_tick, fall_tick);
  modport slave  (input sw, output db_level, rise_tick, fall_tick);
endinterface

// File: rtl/debounce_channel.sv
// One debounce FSMD: settles a single synchronous input over 2^N cycles and
// produces a registered level with registered rise/fall ticks.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick
);

  db_state_e      state_q, state_d;
  logic [N-1:0]   count_q, count_d;
  logic           db_level_q, db_level_d;
  logic           rise_tick_q, rise_tick_d;
  logic           fall_tick_q, fall_tick_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      ZERO: begin
        if (s) begin
          state_d = WAIT1;
          count_d = '1;
        end
      end
      WAIT1: begin
        if (!s) begin
          state_d = ZERO;
        end else begin
          count_d = count_q - 1'b1;
          if (count_d == '0) state_d = ONE;
        end
      end
      ONE: begin
        if (!s) begin
          state_d = WAIT0;
          count_d = '1;
        end
      end
      WAIT0: begin
        if (s) begin
          state_d = ONE;
        end else begin
          count_d = count_q - 1'b1;
          if (count_d == '0) state_d = ZERO;
        end
      end
      default: state_d = ZERO;
    endcase
  end

  // Level is taken from the current state register, so it (and the ticks
  // derived from its change) lands one edge after the state transition,
  // giving exactly 2^N cycles from the first settling sample.
  always_comb begin
    db_level_d  = (state_q == ONE) || (state_q == WAIT0);
    rise_tick_d = db_level_d & ~db_level_q;
    fall_tick_d = ~db_level_d & db_level_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ZERO;
      count_q     <= '0;
      db_level_q  <= 1'b0;
      rise_tick_q <= 1'b0;
      fall_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      db_level_q  <= db_level_d;
      rise_tick_q <= rise_tick_d;
      fall_tick_q <= fall_tick_d;
    end
  end

  assign db_level  = db_level_q;
  assign rise_tick = rise_tick_q;
  assign fall_tick = fall_tick_q;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: CH independent debounce_channel instances.
// Define DEBOUNCE_SYNC_EN to insert a 2-flop synchroniser on every sw bit.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned CH = DEFAULT_CH,
  parameter int unsigned N  = DEFAULT_N
) (
  input  logic             clk,
  input  logic             reset,
  debounce_multi_if.slave  bus
);

  logic [CH-1:0] s;
  logic [CH-1:0] db_level_w;
  logic [CH-1:0] rise_tick_w;
  logic [CH-1:0] fall_tick_w;

`ifdef DEBOUNCE_SYNC_EN
  logic [CH-1:0] sync1_q, sync1_d;
  logic [CH-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = bus.sw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign s = sync2_q;
`else
  assign s = bus.sw;
`endif

  for (genvar i = 0; i < CH; i++) begin : g_ch
    debounce_channel #(
      .N (N)
    ) u_channel (
      .clk       (clk),
      .reset     (reset),
      .s         (s[i]),
      .db_level  (db_level_w[i]),
      .rise_tick (rise_tick_w[i]),
      .fall_tick (fall_tick_w[i])
    );
  end

  assign bus.db_level  = db_level_w;
  assign bus.rise_tick = rise_tick_w;
  assign bus.fall_tick = fall_tick_w;

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: directed and random switch activity
// against a run-length model of debouncing; a monitor compares every cycle.
module tb_debounce_multi;

  localparam int unsigned CH     = 4;
  localparam int unsigned N      = 4;
  localparam int unsigned SETTLE = 1 << N;

  logic clk = 1'b0;
  logic reset;

  debounce_multi_if #(.CH(CH)) bus ();

  debounce_multi #(
    .CH (CH),
    .N  (N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] lvl;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   run_en   = 1'b0;

  // Model: a channel's level flips once its input has disagreed with the
  // current level for SETTLE consecutive samples; outputs show it one edge later.
  logic [CH-1:0] m_lvl;
  int            m_run [CH];
  logic [CH-1:0] m_pipe1, m_pipe2;

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at time %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl   = '0;
    m_pipe1 = '0;
    m_pipe2 = '0;
    for (int i = 0; i < CH; i++) m_run[i] = 0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  always @(posedge clk) begin
    if (run_en) begin
      logic [CH-1:0] s;
      exp_t e;
`ifdef DEBOUNCE_SYNC_EN
      s       = m_pipe2;
      m_pipe2 = m_pipe1;
      m_pipe1 = bus.sw;
`else
      s = bus.sw;
`endif
      e = '0;
      for (int i = 0; i < CH; i++) begin
        if (s[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == SETTLE) begin
            m_lvl[i] = s[i];
            m_run[i] = 0;
            if (s[i]) e.rise[i] = 1'b1;
            else      e.fall[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      e.lvl = m_lvl;
      exp_q.push_back(e);
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (run_en) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: got no expected entry, required one at time %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("db_level",  bus.db_level,  e.lvl);
        check("rise_tick", bus.rise_tick, e.rise);
        check("fall_tick", bus.fall_tick, e.fall);
      end
    end
  end

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset  = 1'b1;
    bus.sw = '0;
    cycles(3);
    check("reset_db_level",  bus.db_level,  '0);
    check("reset_rise_tick", bus.rise_tick, '0);
    check("reset_fall_tick", bus.fall_tick, '0);
    model_reset();
    reset  = 1'b0;
    run_en = 1'b1;
    cycles(4);

    // Clean step on channel 0
    bus.sw[0] = 1'b1;
    cycles(SETTLE + 6);

    // Channel 1: one-cycle dropout at cycle 10 restarts the settle
    bus.sw[1] = 1'b1;
    cycles(10);
    bus.sw[1] = 1'b0;
    cycles(1);
    bus.sw[1] = 1'b1;
    cycles(SETTLE + 4);

    // Channel 2: settle high, 3-cycle low glitch, then a real fall
    bus.sw[2] = 1'b1;
    cycles(SETTLE + 4);
    bus.sw[2] = 1'b0;
    cycles(3);
    bus.sw[2] = 1'b1;
    cycles(SETTLE + 2);
    bus.sw[2] = 1'b0;
    cycles(SETTLE + 4);

    // All channels stepped together
    bus.sw = '0;
    cycles(SETTLE + 4);
    bus.sw = '1;
    cycles(SETTLE + 4);
    check("all_high_level", bus.db_level, '1);

    // Reset 8 cycles into a falling settle on channels 2 and 3
    bus.sw = 4'b0011;
    cycles(8);
    run_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_level", bus.db_level,  '0);
    check("async_reset_rise",  bus.rise_tick, '0);
    check("async_reset_fall",  bus.fall_tick, '0);
    cycles(3);
    check("held_reset_level", bus.db_level | bus.rise_tick | bus.fall_tick, '0);
    model_reset();
    reset  = 1'b0;
    run_en = 1'b1;
    cycles(SETTLE + 6);

    // Random toggling, sparse enough that some settles complete
    repeat (3000) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 19) == 0) bus.sw[i] = ~bus.sw[i];
      cycles(1);
    end
    cycles(SETTLE + 4);

    run_en = 1'b0;
    cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
